qspi_psram_target: RTL and testbench
====================================

Name: qspi_psram_target

Overview:
- Synthesizable QSPI PSRAM target: the device end of the SoC's quad-SPI memory interface.
- Decodes serial-command / quad-address / quad-data transactions driven on cen/sclk/sio and serves them from an internal byte array.
- Used as the on-FPGA PSRAM stand-in and as the bus-functional responder in SoC simulation.
- Oversamples sclk in the clk domain; clk must be at least 4x the sclk frequency.

Parameters:
- MEM_BYTES, 65536: backing array size in bytes; power of two.
- WAIT_CYCLES, 6: dummy sclk cycles between the address and the first data nibble for 0xEB.
- SYNC_STAGES, 2: synchronizer depth on cen, sclk and sio_i.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- cen  input  1  chip enable, active-low, from the initiator
- sclk  input  1  SPI clock from the initiator; idles low
- sio_i  input  4  sio3..sio0 input pins
- sio_o  output  4  sio3..sio0 output values
- sio_oe  output  4  per-pin output enable, 1 = drive
- busy  output  1  a transaction is in progress (cen sampled low)
- cmd_err  output  1  sticky flag: an unknown command was received; cleared by reset only

Behaviour:
- Reset and input synchronization:
  - Reset is asynchronous active-low. On reset: sio_o=0, sio_oe=0, busy=0, cmd_err=0, FSM=IDLE, all counters 0. Array contents are unchanged.
  - cen, sclk and sio_i pass through SYNC_STAGES flops.
  - rise = sclk_s & ~sclk_q; fall = ~sclk_s & sclk_q.
- Abort on cen:
  - cen_s high in any state forces IDLE in the next clk, sets sio_oe=0 and busy=0.
  - Any partial write byte is discarded, so a mid-transfer abort is clean.
- FSM states: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE.
  - IDLE: on cen_s low go to CMD, clear the bit counter, set busy=1.
  - CMD: shift sio_s[0] MSB-first on each rise. After 8 bits:
    - 0xEB or 0x38: go to ADDR in quad mode.
    - 0x03 or 0x02: go to ADDR in serial mode.
    - 0x66 or 0x99: go to IGNORE.
    - any other value: set cmd_err=1 and go to IGNORE.
  - ADDR: shift 24 address bits MSB-first, one nibble (sio_s[3:0]) per rise in quad mode, one bit (sio_s[0]) per rise in serial mode. Store addr[$clog2(MEM_BYTES)-1:0]. Exit after 6 or 24 rises:
    - 0xEB: go to DUMMY.
    - 0x03: go directly to RD_DATA; there are no dummy cycles.
    - 0x38 or 0x02: go to WR_DATA.
  - DUMMY: count WAIT_CYCLES rises. Issue the array read of addr in the clk after entry; this read has 1 clk latency.
  - The first data output is driven on the fall that follows the last dummy rise (for 0x03, on the fall after the last address rise). It is therefore stable before the initiator's next sampling rise.
  - RD_DATA:
    - Quad: sio_oe=4'hF. Drive byte[7:4] then byte[3:0], each update on a fall.
    - Serial: sio_oe=4'b0010. Drive sio_o[1] MSB-first, 8 falls per byte.
    - When the last nibble or bit of a byte is loaded, addr increments and the next byte read is issued, keeping 1-byte prefetch ahead of the output.
  - WR_DATA:
    - Sample sio_s[3:0] (high nibble first) or sio_s[0] on each rise.
    - Once a byte is complete, write mem[addr] on the next clk, then increment addr.
  - IGNORE: hold sio_oe=0 until cen_s rises.
- Address wrap: addr increments modulo MEM_BYTES. Address bits above the array width are ignored.
- Initiator ownership: sio_oe=0 in every state except RD_DATA, so the target never drives while the initiator owns the bus.
- Edge cases:
  - A rise and a cen deassert in the same clk: the cen deassert wins.
  - A write byte in its final clk when cen rises is still committed only if it completed on an earlier rise.

Decomposition:
- Shared package or defines header holds the command opcodes (CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, CMD_READ=8'h03, CMD_WRITE=8'h02, CMD_RSTEN=8'h66, CMD_RST=8'h99), the FSM state encodings, and ADDR_BITS=24.
- One sub-module, spi_edge_sync: synchronizer plus rise/fall detection. The byte array is inferred inline as a single-port BRAM.

Test Plan:
- Quad write then read: 0x38, addr 0x000010, bytes A5 3C. Then 0xEB, addr 0x000010, 6 dummy cycles, 2 bytes. Required: nibbles A,5,3,C returned, with sio_oe=F only during data.
- Serial read: preload mem[0x20]=0x81. Issue 0x03, addr 0x000020, 8 clocks. Required: sio1 carries 1,0,0,0,0,0,0,1; sio_oe=4'b0010 during data.
- Wrap: MEM_BYTES=65536. Quad write 3 bytes 11 22 33 at addr 0x00FFFF. Required: mem[0xFFFF]=11, mem[0]=22, mem[1]=33.
- Abort: 0x38 at addr 0x40, full byte 0x77, then one nibble 0x9, then cen high. Required: mem[0x40]=0x77, mem[0x41] unchanged, FSM in IDLE within SYNC_STAGES+1 clk.
- Unknown command 0x5A. Required: cmd_err=1 and sio_oe=0 until cen rises. A following 0xEB transaction completes normally and cmd_err stays 1.
- Async reset asserted mid-RD_DATA. Required: sio_oe=0 and busy=0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/qspi_psram_target_pkg.sv
// Shared opcodes, FSM encoding and command helpers for the QSPI PSRAM target.
package qspi_psram_target_pkg;

    localparam int unsigned ADDR_BITS = 24;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_RSTEN  = 8'h66;
    localparam logic [7:0] CMD_RST    = 8'h99;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_IGNORE
    } state_t;

    // Opcodes that move address and data four bits per sclk.
    function automatic logic is_quad_cmd(input logic [7:0] c);
        return (c == CMD_QREAD) || (c == CMD_QWRITE);
    endfunction

    // Opcodes the target recognises; anything else raises cmd_err.
    function automatic logic is_known_cmd(input logic [7:0] c);
        return (c == CMD_QREAD) || (c == CMD_QWRITE) || (c == CMD_READ) ||
               (c == CMD_WRITE) || (c == CMD_RSTEN) || (c == CMD_RST);
    endfunction

endpackage

// File: rtl/qspi_psram_target_spi_edge_sync.sv
// Synchronizes the initiator pins into clk and detects sclk edges.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cen,
    input  logic       sclk,
    input  logic [3:0] sio_i,
    output logic       cen_s,
    output logic [3:0] sio_s,
    output logic       rise_c,
    output logic       fall_c
);

    logic [SYNC_STAGES-1:0] cen_sr;
    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [3:0]             sio_sr [SYNC_STAGES];
    logic                   sclk_q;
    logic                   sclk_s;

    // Synchronizer chains; cen resets to the deselected level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cen_sr  <= '1;
            sclk_sr <= '0;
            sclk_q  <= 1'b0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) sio_sr[i] <= '0;
        end else begin
            cen_sr[0]  <= cen;
            sclk_sr[0] <= sclk;
            sio_sr[0]  <= sio_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                cen_sr[i]  <= cen_sr[i-1];
                sclk_sr[i] <= sclk_sr[i-1];
                sio_sr[i]  <= sio_sr[i-1];
            end
            sclk_q <= sclk_s;
        end
    end

    assign cen_s  = cen_sr[SYNC_STAGES-1];
    assign sclk_s = sclk_sr[SYNC_STAGES-1];
    assign sio_s  = sio_sr[SYNC_STAGES-1];
    assign rise_c = sclk_s & ~sclk_q;
    assign fall_c = ~sclk_s & sclk_q;

endmodule

// File: rtl/qspi_psram_target.sv
// QSPI PSRAM target: decodes cmd/addr/data transactions and serves an internal byte array.
module qspi_psram_target
    import qspi_psram_target_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 65536,
    parameter int unsigned WAIT_CYCLES = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cen,
    input  logic       sclk,
    input  logic [3:0] sio_i,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe,
    output logic       busy,
    output logic       cmd_err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned CW = 8;

    logic       cen_s;
    logic [3:0] sio_s;
    logic       rise_c;
    logic       fall_c;

    state_t         state_q;
    state_t         state_n;
    logic           quad_q;
    logic [7:0]     cmd_q;
    logic [CW-1:0]  cnt_q;
    logic [AW-1:0]  addr_q;
    logic [7:0]     rd_data_q;
    logic [7:0]     out_q;
    logic [7:0]     wr_sr_q;
    logic [7:0]     wr_byte_q;
    logic           rd_req_q;
    logic           wr_pend_q;
    logic [7:0]     mem [MEM_BYTES];

    logic [7:0] cmd_now_c;
    logic [7:0] wr_next_c;
    logic       wr_done_c;
    logic       addr_last_c;
    logic       busy_c;
    logic [3:0] oe_c;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .cen    (cen),
        .sclk   (sclk),
        .sio_i  (sio_i),
        .cen_s  (cen_s),
        .sio_s  (sio_s),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    assign cmd_now_c   = {cmd_q[6:0], sio_s[0]};
    assign wr_next_c   = quad_q ? {wr_sr_q[3:0], sio_s} : {wr_sr_q[6:0], sio_s[0]};
    assign wr_done_c   = quad_q ? cnt_q[0] : (cnt_q[2:0] == 3'd7);
    assign addr_last_c = (cnt_q == (quad_q ? CW'(ADDR_BITS/4 - 1) : CW'(ADDR_BITS - 1)));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_n;
    end

    // Next-state decode; a deselected cen overrides everything, including a coincident rise.
    always_comb begin
        state_n = state_q;
        if (cen_s) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_n = ST_CMD;
                ST_CMD: if (rise_c && cnt_q == CW'(7)) begin
                    case (cmd_now_c)
                        CMD_QREAD, CMD_QWRITE, CMD_READ, CMD_WRITE: state_n = ST_ADDR;
                        default:                                    state_n = ST_IGNORE;
                    endcase
                end
                ST_ADDR: if (rise_c && addr_last_c) begin
                    case (cmd_q)
                        CMD_QREAD: state_n = ST_DUMMY;
                        CMD_READ:  state_n = ST_RD_DATA;
                        default:   state_n = ST_WR_DATA;
                    endcase
                end
                ST_DUMMY: if (rise_c && cnt_q == CW'(WAIT_CYCLES - 1)) state_n = ST_RD_DATA;
                ST_RD_DATA, ST_WR_DATA, ST_IGNORE: state_n = state_q;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Next values of the pin enables and busy; only RD_DATA drives the bus.
    always_comb begin
        busy_c = 1'b0;
        oe_c   = 4'h0;
        busy_c = (state_n != ST_IDLE);
        if (state_n == ST_RD_DATA) oe_c = quad_q ? 4'hF : 4'b0010;
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sio_oe <= 4'h0;
            busy   <= 1'b0;
        end else begin
            sio_oe <= oe_c;
            busy   <= busy_c;
        end
    end

    // Shift registers, counters, address pointer and read/write sequencing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quad_q    <= 1'b0;
            cmd_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            out_q     <= '0;
            wr_sr_q   <= '0;
            wr_byte_q <= '0;
            rd_req_q  <= 1'b0;
            wr_pend_q <= 1'b0;
            sio_o     <= 4'h0;
            cmd_err   <= 1'b0;
        end else begin
            rd_req_q  <= 1'b0;
            wr_pend_q <= 1'b0;

            if (state_n != state_q)                                   cnt_q <= '0;
            else if ((state_q == ST_RD_DATA) ? fall_c : rise_c)       cnt_q <= cnt_q + CW'(1);

            if (state_q == ST_CMD && rise_c && !cen_s) begin
                cmd_q <= cmd_now_c;
                if (cnt_q == CW'(7)) begin
                    quad_q <= is_quad_cmd(cmd_now_c);
                    if (!is_known_cmd(cmd_now_c)) cmd_err <= 1'b1;
                end
            end

            if (state_q == ST_ADDR && rise_c && !cen_s)
                addr_q <= quad_q ? {addr_q[AW-5:0], sio_s} : {addr_q[AW-2:0], sio_s[0]};

            // First array read is issued once the final address bits have landed.
            if (state_q == ST_ADDR && (state_n == ST_DUMMY || state_n == ST_RD_DATA))
                rd_req_q <= 1'b1;

            if (state_n != ST_RD_DATA) begin
                sio_o <= 4'h0;
            end else if (state_q == ST_RD_DATA && fall_c) begin
                if (quad_q) begin
                    if (!cnt_q[0]) begin
                        out_q <= rd_data_q;
                        sio_o <= rd_data_q[7:4];
                    end else begin
                        sio_o    <= out_q[3:0];
                        addr_q   <= addr_q + AW'(1);
                        rd_req_q <= 1'b1;
                    end
                end else begin
                    if (cnt_q[2:0] == 3'd0) begin
                        out_q <= {rd_data_q[6:0], 1'b0};
                        sio_o <= {2'b00, rd_data_q[7], 1'b0};
                    end else begin
                        out_q <= {out_q[6:0], 1'b0};
                        sio_o <= {2'b00, out_q[7], 1'b0};
                    end
                    if (cnt_q[2:0] == 3'd7) begin
                        addr_q   <= addr_q + AW'(1);
                        rd_req_q <= 1'b1;
                    end
                end
            end

            if (state_q == ST_WR_DATA && state_n == ST_WR_DATA && rise_c) begin
                wr_sr_q <= wr_next_c;
                if (wr_done_c) begin
                    wr_byte_q <= wr_next_c;
                    wr_pend_q <= 1'b1;
                end
            end

            // A byte completed on an earlier rise commits even if cen has since risen.
            if (wr_pend_q) addr_q <= addr_q + AW'(1);
        end
    end

    // Single-port byte array; reads and writes never coincide.
    always_ff @(posedge clk) begin
        if (wr_pend_q)     mem[addr_q] <= wr_byte_q;
        else if (rd_req_q) rd_data_q   <= mem[addr_q];
    end

endmodule

// File: tb/tb_qspi_psram_target.sv
// Directed bench for qspi_psram_target with a scoreboard on read data.
module tb_qspi_psram_target;

    localparam int unsigned WAIT = 6;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       cen    = 1'b1;
    logic       sclk   = 1'b0;
    logic [3:0] sio_i  = 4'h0;
    logic [3:0] sio_o;
    logic [3:0] sio_oe;
    logic       busy;
    logic       cmd_err;

    typedef struct packed {
        logic [3:0] oe;
        logic [3:0] mask;
        logic [3:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    qspi_psram_target #(
        .MEM_BYTES   (65536),
        .WAIT_CYCLES (WAIT),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .cen     (cen),
        .sclk    (sclk),
        .sio_i   (sio_i),
        .sio_o   (sio_o),
        .sio_oe  (sio_oe),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    // Monitor: at each initiator sampling rise where the target drives, pop and compare.
    always @(posedge sclk) begin
        exp_t e;
        if (sio_oe !== 4'h0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_drive: sio_oe=%h sio_o=%h with nothing expected", sio_oe, sio_o);
            end else begin
                e = exp_q.pop_front();
                if (sio_oe !== e.oe || (sio_o & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL read_data: got oe=%h sio=%h required oe=%h sio=%h (mask %h)",
                             sio_oe, sio_o & e.mask, e.oe, e.val, e.mask);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic pulse(input logic [3:0] d);
        sio_i = d;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic begin_xfer();
        @(negedge clk);
        cen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_xfer();
        cen   = 1'b1;
        sio_i = 4'h0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) pulse({3'b000, c[i]});
    endtask

    task automatic send_addr(input logic [23:0] a, input bit quad);
        if (quad) for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4]);
        else      for (int i = 23; i >= 0; i--) pulse({3'b000, a[i]});
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit quad);
        if (quad) begin
            pulse(b[7:4]);
            pulse(b[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]});
        end
    endtask

    task automatic rd_byte(input logic [7:0] b, input bit quad);
        exp_t e;
        if (quad) begin
            e = '{oe: 4'hF, mask: 4'hF, val: b[7:4]};
            exp_q.push_back(e);
            pulse(4'h0);
            e = '{oe: 4'hF, mask: 4'hF, val: b[3:0]};
            exp_q.push_back(e);
            pulse(4'h0);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                e = '{oe: 4'b0010, mask: 4'b0010, val: {2'b00, b[i], 1'b0}};
                exp_q.push_back(e);
                pulse(4'h0);
            end
        end
    endtask

    task automatic quad_read_hdr(input logic [23:0] a);
        begin_xfer();
        send_cmd(8'hEB);
        send_addr(a, 1'b1);
        repeat (WAIT - 1) pulse(4'h0);
        check("oe_during_dummy", sio_oe, 4'h0);
        pulse(4'h0);
    endtask

    initial begin
        #23;
        check("reset_sio_oe", sio_oe, 4'h0);
        check("reset_sio_o", sio_o, 4'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_cmd_err", cmd_err, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Quad write A5 3C at 0x10, then quad read back.
        begin_xfer();
        send_cmd(8'h38);
        check("busy_in_cmd", busy, 1'b1);
        send_addr(24'h000010, 1'b1);
        wr_byte(8'hA5, 1'b1);
        wr_byte(8'h3C, 1'b1);
        end_xfer();
        check("idle_after_write", busy, 1'b0);

        quad_read_hdr(24'h000010);
        rd_byte(8'hA5, 1'b1);
        rd_byte(8'h3C, 1'b1);
        end_xfer();
        check("oe_after_read", sio_oe, 4'h0);

        // Serial writes preload 0x20 and 0x41, then a serial read of 0x20.
        begin_xfer(); send_cmd(8'h02); send_addr(24'h000020, 1'b0); wr_byte(8'h81, 1'b0); end_xfer();
        begin_xfer(); send_cmd(8'h02); send_addr(24'h000041, 1'b0); wr_byte(8'hC3, 1'b0); end_xfer();
        begin_xfer();
        send_cmd(8'h03);
        send_addr(24'h000020, 1'b0);
        rd_byte(8'h81, 1'b0);
        end_xfer();

        // Wrap across the top of the array.
        begin_xfer();
        send_cmd(8'h38);
        send_addr(24'h00FFFF, 1'b1);
        wr_byte(8'h11, 1'b1);
        wr_byte(8'h22, 1'b1);
        wr_byte(8'h33, 1'b1);
        end_xfer();
        quad_read_hdr(24'h00FFFF);
        rd_byte(8'h11, 1'b1); rd_byte(8'h22, 1'b1); rd_byte(8'h33, 1'b1);
        end_xfer();
        quad_read_hdr(24'h000000);
        rd_byte(8'h22, 1'b1); rd_byte(8'h33, 1'b1);
        end_xfer();

        // Address bits above the array width are ignored.
        quad_read_hdr(24'h3C0010);
        rd_byte(8'hA5, 1'b1);
        end_xfer();

        // Abort mid-byte: full 0x77 commits, trailing nibble is dropped.
        begin_xfer();
        send_cmd(8'h38);
        send_addr(24'h000040, 1'b1);
        wr_byte(8'h77, 1'b1);
        pulse(4'h9);
        cen = 1'b1;
        sio_i = 4'h0;
        repeat (3) @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_oe", sio_oe, 4'h0);
        repeat (4) @(negedge clk);
        quad_read_hdr(24'h000040);
        rd_byte(8'h77, 1'b1);
        rd_byte(8'hC3, 1'b1);
        end_xfer();

        // Known no-op command leaves cmd_err clear.
        begin_xfer();
        send_cmd(8'h66);
        repeat (2) pulse(4'h0);
        check("rsten_no_err", cmd_err, 1'b0);
        end_xfer();

        // Unknown command sets sticky cmd_err and keeps the bus released.
        begin_xfer();
        send_cmd(8'h5A);
        repeat (3) pulse(4'hF);
        check("unknown_cmd_err", cmd_err, 1'b1);
        check("unknown_oe", sio_oe, 4'h0);
        check("unknown_busy", busy, 1'b1);
        end_xfer();
        check("cmd_err_sticky", cmd_err, 1'b1);
        quad_read_hdr(24'h000010);
        rd_byte(8'hA5, 1'b1);
        end_xfer();
        check("cmd_err_after_read", cmd_err, 1'b1);

        // Async reset in the middle of read data.
        quad_read_hdr(24'h000010);
        rd_byte(8'hA5, 1'b1);
        check("busy_in_read", busy, 1'b1);
        check("oe_in_read", sio_oe, 4'hF);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_oe", sio_oe, 4'h0);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_cmd_err", cmd_err, 1'b0);
        cen = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
